// File: rtl/alu_pkg.sv
// Shared definitions for the RV32I integer ALU and the instruction decoder.
//   XLEN      : operand/result width
//   F3_*      : RV32I funct3 encodings for register-register/immediate ALU ops
package alu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_SLTU   = 3'b011;
  localparam logic [2:0] F3_XOR    = 3'b100;
  localparam logic [2:0] F3_SR     = 3'b101;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

endpackage

// File: rtl/alu_core.sv
// Combinational RV32I ALU datapath.
//   operand_a_i : operand A (rs1)
//   operand_b_i : operand B (rs2 or immediate); [4:0] is the shift amount
//   funct3_i    : operation select
//   funct7_i    : instruction bit 30; SUB vs ADD, SRA vs SRL
//   result_o    : operation result
module alu_core #(
  parameter int unsigned XLEN = alu_pkg::XLEN
) (
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  input  logic [2:0]      funct3_i,
  input  logic            funct7_i,
  output logic [XLEN-1:0] result_o
);
  import alu_pkg::*;

  logic [4:0] shamt;
  assign shamt = operand_b_i[4:0];

  always_comb begin
    result_o = '0;
    // Unknown select values fall into the defaults so no X leaks to the result.
    case (funct3_i)
      F3_ADDSUB: begin
        case (funct7_i)
          1'b0:    result_o = operand_a_i + operand_b_i;
          1'b1:    result_o = operand_a_i - operand_b_i;
          default: result_o = '0;
        endcase
      end
      F3_SLL:  result_o = operand_a_i << shamt;
      F3_SLT:  result_o = {{(XLEN-1){1'b0}}, ($signed(operand_a_i) < $signed(operand_b_i))};
      F3_SLTU: result_o = {{(XLEN-1){1'b0}}, (operand_a_i < operand_b_i)};
      F3_XOR:  result_o = operand_a_i ^ operand_b_i;
      F3_SR: begin
        case (funct7_i)
          1'b0:    result_o = operand_a_i >> shamt;
          1'b1:    result_o = $unsigned($signed(operand_a_i) >>> shamt);
          default: result_o = '0;
        endcase
      end
      F3_OR:   result_o = operand_a_i | operand_b_i;
      F3_AND:  result_o = operand_a_i & operand_b_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// RV32I integer ALU with a registered result (one cycle latency, no stalls).
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset; clears aluout
//   aluin1 : operand A (rs1)
//   aluin2 : operand B (rs2 or immediate); [4:0] is the shift amount
//   funct3 : operation select
//   funct7 : instruction bit 30; SUB vs ADD, SRA vs SRL
//   aluout : registered result
module alu #(
  parameter int unsigned XLEN = alu_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] aluin1,
  input  logic [XLEN-1:0] aluin2,
  input  logic [2:0]      funct3,
  input  logic            funct7,
  output logic [XLEN-1:0] aluout
);

  logic [XLEN-1:0] result_d;
  logic [XLEN-1:0] result_q;

  alu_core #(
    .XLEN(XLEN)
  ) u_alu_core (
    .operand_a_i(aluin1),
    .operand_b_i(aluin2),
    .funct3_i   (funct3),
    .funct7_i   (funct7),
    .result_o   (result_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign aluout = result_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: the driver pushes the expected result when it
// applies a vector; the monitor pops and compares one cycle later.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] aluin1;
  logic [31:0] aluin2;
  logic [2:0]  funct3;
  logic        funct7;
  logic [31:0] aluout;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec;
  int   n_err;

  alu u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .aluin1(aluin1),
    .aluin2(aluin2),
    .funct3(funct3),
    .funct7(funct7),
    .aluout(aluout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Op index: 0 ADD 1 SUB 2 SLL 3 SLT 4 SLTU 5 XOR 6 SRL 7 SRA 8 OR 9 AND
  function automatic logic [2:0] op_f3(input int op);
    logic [2:0] tbl [10];
    tbl = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
    return tbl[op];
  endfunction

  function automatic logic op_f7(input int op);
    return (op == 1) || (op == 7);
  endfunction

  // Independent reference model: shifts done bit by bit.
  function automatic logic [31:0] ref_model(input int op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    int          s;
    s = int'(b[4:0]);
    r = '0;
    case (op)
      0: r = a + b;
      1: r = a + (~b) + 32'd1;
      2: for (int i = 0; i < 32; i++) r[i] = (i >= s) ? a[i-s] : 1'b0;
      3: r = (a[31] != b[31]) ? {31'b0, a[31]} : {31'b0, a < b};
      4: r = {31'b0, a < b};
      5: r = a ^ b;
      6: for (int i = 0; i < 32; i++) r[i] = (i + s < 32) ? a[i+s] : 1'b0;
      7: for (int i = 0; i < 32; i++) r[i] = (i + s < 32) ? a[i+s] : a[31];
      8: r = a | b;
      9: r = a & b;
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic drive(input logic [2:0] f3, input logic f7, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input string name);
    exp_t e;
    @(negedge clk);
    funct3 = f3;
    funct7 = f7;
    aluin1 = a;
    aluin2 = b;
    e.exp  = exp;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] exp);
    n_vec++;
    if (aluout !== exp) begin
      n_err++;
      $display("FAIL %s: aluout=%08h expected=%08h", name, aluout, exp);
    end
  endtask

  // Monitor: a vector pushed at the negedge is registered at this posedge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.name, e.exp);
    end
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    n_vec  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    aluin1 = '0;
    aluin2 = '0;
    funct3 = 3'd0;
    funct7 = 1'b0;
    #1;
    check("reset_initial", 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Main table, A=7, B=0x8000000A
    drive(3'b000, 1'b0, 32'h00000007, 32'h8000000A, 32'h80000011, "add");
    drive(3'b000, 1'b1, 32'h00000007, 32'h8000000A, 32'h7FFFFFFD, "sub");
    drive(3'b001, 1'b0, 32'h00000007, 32'h8000000A, 32'h00001C00, "sll");
    drive(3'b010, 1'b0, 32'h00000007, 32'h8000000A, 32'h00000000, "slt");
    drive(3'b011, 1'b0, 32'h00000007, 32'h8000000A, 32'h00000001, "sltu");
    drive(3'b100, 1'b0, 32'h00000007, 32'h8000000A, 32'h8000000D, "xor");
    drive(3'b110, 1'b0, 32'h00000007, 32'h8000000A, 32'h8000000F, "or");
    drive(3'b111, 1'b0, 32'h00000007, 32'h8000000A, 32'h00000002, "and");
    drive(3'b101, 1'b0, 32'h80000007, 32'h8000000A, 32'h00200000, "srl");
    drive(3'b101, 1'b1, 32'h80000007, 32'h8000000A, 32'hFFE00000, "sra");
    // funct7 ignored outside ADD/SUB and shifts-right
    drive(3'b001, 1'b1, 32'h00000007, 32'h8000000A, 32'h00001C00, "sll_f7");
    drive(3'b111, 1'b1, 32'h00000007, 32'h8000000A, 32'h00000002, "and_f7");
    drive(3'b010, 1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, "slt_neg_f7");

    // Boundaries
    drive(3'b000, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, "add_wrap");
    drive(3'b000, 1'b1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, "sub_wrap");
    drive(3'b010, 1'b0, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, "slt_minint");
    drive(3'b011, 1'b0, 32'h80000000, 32'h7FFFFFFF, 32'h00000000, "sltu_minint");
    drive(3'b010, 1'b0, 32'h12345678, 32'h12345678, 32'h00000000, "slt_eq");
    drive(3'b011, 1'b0, 32'h12345678, 32'h12345678, 32'h00000000, "sltu_eq");
    drive(3'b001, 1'b0, 32'hA5A5A5A5, 32'h00000020, 32'hA5A5A5A5, "sll_by32");
    drive(3'b101, 1'b0, 32'hA5A5A5A5, 32'h00000020, 32'hA5A5A5A5, "srl_by32");
    drive(3'b101, 1'b1, 32'hA5A5A5A5, 32'hFFFFFFE0, 32'hA5A5A5A5, "sra_by0_hi");
    drive(3'b101, 1'b1, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, "sra_31");

    // Back-to-back random over all ops, no bubbles
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      drive(op_f3(i % 10), op_f7(i % 10), a, b, ref_model(i % 10, a, b),
            $sformatf("rand%0d_op%0d", i, i % 10));
    end

    // Unknown select: every op of 0,0 is 0, so the result is 0 either way
    drive(3'b110, 1'b0, 32'h0000F00D, 32'h00000000, 32'h0000F00D, "pre_x");
    drive(3'bxxx, 1'bx, 32'h00000000, 32'h00000000, 32'h00000000, "funct_x");
    drive(3'b000, 1'bx, 32'h00000000, 32'h00000000, 32'h00000000, "funct7_x");

    // Reset mid-run with a nonzero result held
    drive(3'b110, 1'b0, 32'h00001234, 32'h00005678, 32'h0000567C, "pre_reset");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("reset_async", 32'h0);
    @(posedge clk);
    #1;
    check("reset_held", 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_released", 32'h0);
    @(posedge clk);
    #1;
    check("first_after_reset", 32'h0000567C);

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
